// File: rtl/sm4_pkg.sv
// Shared SM4 definitions: FK/CK constants, the key-schedule linear transform and FSM states.
// The WIPE state exists only when SM4_KS_ZEROIZE_EN is defined.
package sm4_pkg;

  localparam int RK_W   = 32;
  localparam int RK_NUM = 32;

  localparam logic [127:0] FK = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

`ifdef SM4_KS_ZEROIZE_EN
  typedef enum logic [2:0] {ST_IDLE, ST_SUB, ST_UPD, ST_READY, ST_WIPE} ks_state_e;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_SUB, ST_UPD, ST_READY} ks_state_e;
`endif

  // CK_i byte j (MSB first) = ((4i + j) * 7) mod 256
  function automatic logic [31:0] sm4_ck(input logic [4:0] i);
    logic [31:0] ck;
    ck = '0;
    for (int j = 0; j < 4; j++) begin
      ck[31-8*j -: 8] = 8'((4 * int'(i) + j) * 7);
    end
    return ck;
  endfunction

  function automatic logic [31:0] sm4_l_key(input logic [31:0] b);
    return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
  endfunction

endpackage

// File: rtl/sm4_key_sched_if.sv
// Key-load handshake and round-key read port of the SM4 key scheduler.
// master = key source / reader, slave = sm4_key_sched.
interface sm4_key_sched_if;
  logic         KEY_VALID_i;
  logic [127:0] KEY_i;
  logic         KEY_READY_o;
  logic         RK_VLD_o;
  logic [4:0]   RK_IDX_i;
  logic         DEC_i;
  logic [31:0]  RK_o;

  modport master (
    output KEY_VALID_i, KEY_i, RK_IDX_i, DEC_i,
    input  KEY_READY_o, RK_VLD_o, RK_o
  );

  modport slave (
    input  KEY_VALID_i, KEY_i, RK_IDX_i, DEC_i,
    output KEY_READY_o, RK_VLD_o, RK_o
  );
endinterface

// File: rtl/sm4_tau.sv
// SM4 tau: four byte-wide S-box lookups, each registered (1-cycle latency).
// Shared by the key schedule and the encrypt/decrypt round datapath.
module sm4_tau (
  input  logic        clk_i,
  input  logic [31:0] x_i,
  output logic [31:0] y_o
);

  localparam logic [2047:0] SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [7:0] sb_q;
    always_ff @(posedge clk_i) begin
      sb_q <= SBOX[2047 - 8*int'(x_i[8*g +: 8]) -: 8];
    end
    assign y_o[8*g +: 8] = sb_q;
  end

endmodule

// File: rtl/sm4_key_sched.sv
// SM4 key expansion: one round key every two cycles (SUB: S-box lookup, UPD: store + shift).
// Defining SM4_KS_ZEROIZE_EN adds ZEROIZE_i and a WIPE state that clears the key store.
module sm4_key_sched
  import sm4_pkg::*;
(
  input  logic CLK_i,
  input  logic RST_i,
`ifdef SM4_KS_ZEROIZE_EN
  input  logic ZEROIZE_i,
`endif
  sm4_key_sched_if.slave bus
);

  // IDLE: no keys | SUB: tau lookup | UPD: write rk, shift K | READY: keys valid | WIPE: zero store
  ks_state_e        state_q, state_d;
  logic [4:0]       round_q, round_d;
  logic [0:3][31:0] k_q, k_d;
  logic             rk_vld_q, rk_vld_d;
  logic [RK_W-1:0]  rk_q;
  logic [RK_W-1:0]  mem [RK_NUM];

  logic             we;
  logic [4:0]       wa;
  logic [RK_W-1:0]  wd;
  logic [31:0]      tau_in, tau_out, rk_new;
  logic [4:0]       rd_idx;
  logic             accept;

  assign tau_in = k_q[1] ^ k_q[2] ^ k_q[3] ^ sm4_ck(round_q);
  assign rk_new = k_q[0] ^ sm4_l_key(tau_out);

  sm4_tau u_tau (
    .clk_i (CLK_i),
    .x_i   (tau_in),
    .y_o   (tau_out)
  );

  assign bus.KEY_READY_o = (state_q == ST_IDLE) || (state_q == ST_READY);
  assign bus.RK_VLD_o    = rk_vld_q;
  assign bus.RK_o        = rk_q;
  assign accept          = bus.KEY_VALID_i && bus.KEY_READY_o;
  assign rd_idx          = bus.DEC_i ? ~bus.RK_IDX_i : bus.RK_IDX_i;

  always_comb begin
    state_d  = state_q;
    round_d  = round_q;
    k_d      = k_q;
    rk_vld_d = rk_vld_q;
    we       = 1'b0;
    wa       = round_q;
    wd       = rk_new;
    case (state_q)
      ST_IDLE, ST_READY: begin
`ifdef SM4_KS_ZEROIZE_EN
        if (ZEROIZE_i) begin
          state_d  = ST_WIPE;
          round_d  = '0;
          rk_vld_d = 1'b0;
        end else
`endif
        if (accept) begin
          state_d  = ST_SUB;
          round_d  = '0;
          k_d      = bus.KEY_i ^ FK;
          rk_vld_d = 1'b0;
        end
      end
      ST_SUB: state_d = ST_UPD;
      ST_UPD: begin
        we      = 1'b1;
        k_d     = {k_q[1], k_q[2], k_q[3], rk_new};
        round_d = round_q + 5'd1;
        if (round_q == 5'd31) begin
          state_d  = ST_READY;
          rk_vld_d = 1'b1;
        end else begin
          state_d = ST_SUB;
        end
      end
`ifdef SM4_KS_ZEROIZE_EN
      ST_WIPE: begin
        we      = 1'b1;
        wd      = '0;
        round_d = round_q + 5'd1;
        if (round_q == 5'd31) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      state_q  <= ST_IDLE;
      round_q  <= '0;
      k_q      <= '0;
      rk_vld_q <= 1'b0;
      rk_q     <= '0;
    end else begin
      state_q  <= state_d;
      round_q  <= round_d;
      k_q      <= k_d;
      rk_vld_q <= rk_vld_d;
      rk_q     <= mem[rd_idx];
    end
  end

  // Key store is deliberately not reset; only a completed expansion makes it valid.
  always_ff @(posedge CLK_i) begin
    if (we && !RST_i) mem[wa] <= wd;
  end

endmodule
